// File: rtl/mos6502_bus_master.sv
// mos6502_bus_master: clocked 6502-style bus initiator for the RRIOT bus.
// It derives PHI2 from the system clock and holds RES low for a fixed number
// of bus cycles. It then runs single read/write bus cycles from a valid/ready
// request port and reports completions on a one-clock response pulse.
module mos6502_bus_master #(
  parameter int PHI_DIV    = 4,
  parameter int RES_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [9:0] req_addr,
  input  logic       req_rs0,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic       rsp_we,
  output logic [7:0] rsp_rdata,
  output logic       phi2_o,
  output logic       res_n_o,
  output logic [9:0] addr_o,
  output logic       rs0_o,
  output logic       r_w_o,
  output logic [7:0] db_o,
  output logic       db_oe,
  input  logic [7:0] db_i,
  input  logic       irq_n_i,
  output logic       irq_n_sync
);

  localparam int CW = $clog2(2 * PHI_DIV);
  localparam int RW = (RES_CYCLES > 1) ? $clog2(RES_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST   = CW'(2 * PHI_DIV - 1);
  localparam logic [CW-1:0] C_PHI2   = CW'(PHI_DIV);
  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [RW-1:0] RES_LAST = RW'(RES_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RES_HOLD,
    S_IDLE,
    S_READ,
    S_WRITE
  } state_t;

  state_t        state;
  logic [CW-1:0] c;
  logic [CW-1:0] c_next;
  logic [RW-1:0] res_cnt;
  logic [7:0]    wdata_q;
  logic          accept;
  logic          irq_meta;

  // Next phase count and request handshake.
  always_comb begin
    c_next = (c == C_LAST) ? '0 : c + 1'b1;
    accept = req_valid & req_ready;
  end

  // Phase counter, bus-cycle FSM and all registered bus/handshake outputs.
  // Outputs are computed from c_next so each one lines up with the phase it
  // belongs to. db_oe follows the pre-edge state, which covers c=1..LAST of a
  // write plus the single hold clock at the following c=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_RES_HOLD;
      c          <= '0;
      res_cnt    <= '0;
      wdata_q    <= '0;
      phi2_o     <= 1'b0;
      res_n_o    <= 1'b0;
      addr_o     <= '0;
      rs0_o      <= 1'b0;
      r_w_o      <= 1'b1;
      db_o       <= '0;
      db_oe      <= 1'b0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_we     <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      c         <= c_next;
      phi2_o    <= (c_next >= C_PHI2);
      rsp_valid <= 1'b0;
      db_oe     <= (state == S_WRITE);
      req_ready <= (c_next == C_LAST) && (state != S_RES_HOLD);

      if ((state == S_WRITE) && (c_next == C_ONE)) begin
        db_o <= wdata_q;
      end

      if (c == C_LAST) begin
        case (state)
          S_RES_HOLD: begin
            if (res_cnt == RES_LAST) begin
              state   <= S_IDLE;
              res_n_o <= 1'b1;
            end else begin
              res_cnt <= res_cnt + 1'b1;
            end
          end
          S_READ: begin
            rsp_valid <= 1'b1;
            rsp_we    <= 1'b0;
            rsp_rdata <= db_i;
          end
          S_WRITE: begin
            rsp_valid <= 1'b1;
            rsp_we    <= 1'b1;
          end
          default: ;
        endcase

        if (state != S_RES_HOLD) begin
          if (accept) begin
            state   <= req_we ? S_WRITE : S_READ;
            addr_o  <= req_addr;
            rs0_o   <= req_rs0;
            r_w_o   <= ~req_we;
            wdata_q <= req_wdata;
          end else begin
            state <= S_IDLE;
            r_w_o <= 1'b1;
          end
        end
      end
    end
  end

  // Two-flop synchronizer for the asynchronous IRQ line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_meta   <= 1'b1;
      irq_n_sync <= 1'b1;
    end else begin
      irq_meta   <= irq_n_i;
      irq_n_sync <= irq_meta;
    end
  end

endmodule

// File: tb/tb_mos6502_bus_master.sv
// Directed self-checking bench for mos6502_bus_master (PHI_DIV=4, RES_CYCLES=8).
module tb_mos6502_bus_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [9:0] req_addr = '0;
  logic       req_rs0 = 1'b0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic       rsp_we;
  logic [7:0] rsp_rdata;
  logic       phi2_o;
  logic       res_n_o;
  logic [9:0] addr_o;
  logic       rs0_o;
  logic       r_w_o;
  logic [7:0] db_o;
  logic       db_oe;
  logic [7:0] db_i = 8'hFF;
  logic       irq_n_i = 1'b1;
  logic       irq_n_sync;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] rd_val = 8'hFF;

  mos6502_bus_master #(.PHI_DIV(4), .RES_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_rs0(req_rs0), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .phi2_o(phi2_o), .res_n_o(res_n_o), .addr_o(addr_o), .rs0_o(rs0_o),
    .r_w_o(r_w_o), .db_o(db_o), .db_oe(db_oe), .db_i(db_i),
    .irq_n_i(irq_n_i), .irq_n_sync(irq_n_sync)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (clk %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Advance one clock and sample #1 after the edge; the device drives read data
  // only while PHI2 is high.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    db_i = ((cyc % 8) >= 4) ? rd_val : 8'hFF;
  endtask

  // Walk the RES hold sequence from release (clk 0) up to the first ready (clk 71).
  task automatic check_res_hold();
    for (int k = 0; k < 72; k++) begin
      check("res_n", res_n_o, (cyc >= 64));
      check("phi2", phi2_o, ((cyc % 8) >= 4));
      check("ready_seq", req_ready, (cyc == 71));
      check("rsp_quiet", rsp_valid, 0);
      if (k < 71) step();
    end
  endtask

  // Present a request, wait (bounded) for ready, take the handshake edge.
  task automatic issue(input logic we, input logic [9:0] a, input logic r, input logic [7:0] d);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_rs0   = r;
    req_wdata = d;
    while (!req_ready && n < 32) begin
      step();
      n++;
    end
    check("ready_seen", req_ready, 1);
    step();
    check("addr_phase", cyc % 8, 0);
  endtask

  initial begin
    int t1;
    int n;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1;
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_res_n", res_n_o, 0);
    check("rst_phi2", phi2_o, 0);
    check("rst_rw", r_w_o, 1);
    check("rst_addr", addr_o, 0);
    check("rst_oe", db_oe, 0);
    check("rst_ready", req_ready, 0);
    check("rst_irq", irq_n_sync, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    check_res_hold();

    // Write 0xA5 to 0x201 with RS0=1.
    issue(1'b1, 10'h201, 1'b1, 8'hA5);
    req_valid = 1'b0;
    check("wr_addr", addr_o, 10'h201);
    check("wr_rw", r_w_o, 0);
    check("wr_rs0", rs0_o, 1);
    check("wr_oe_c0", db_oe, 0);
    for (int k = 1; k < 8; k++) begin
      step();
      check("wr_oe", db_oe, 1);
      check("wr_db", db_o, 8'hA5);
      check("wr_addr_hold", addr_o, 10'h201);
      check("wr_rsp_early", rsp_valid, 0);
    end
    step();
    check("wr_rsp", rsp_valid, 1);
    check("wr_rsp_we", rsp_we, 1);
    check("wr_hold_oe", db_oe, 1);
    check("wr_hold_db", db_o, 8'hA5);
    check("wr_rdata_keep", rsp_rdata, 0);
    check("idle_rw", r_w_o, 1);
    step();
    check("wr_oe_off", db_oe, 0);
    check("wr_rsp_pulse", rsp_valid, 0);

    // Read 0x200, device returns 0x3C during PHI2 high.
    rd_val = 8'h3C;
    issue(1'b0, 10'h200, 1'b0, 8'h00);
    req_valid = 1'b0;
    check("rd_addr", addr_o, 10'h200);
    check("rd_rw", r_w_o, 1);
    check("rd_rs0", rs0_o, 0);
    for (int k = 1; k < 8; k++) begin
      step();
      check("rd_oe", db_oe, 0);
      check("rd_rsp_early", rsp_valid, 0);
    end
    step();
    check("rd_rsp", rsp_valid, 1);
    check("rd_rsp_we", rsp_we, 0);
    check("rd_data", rsp_rdata, 8'h3C);
    step();
    check("rd_rsp_pulse", rsp_valid, 0);
    check("rd_data_hold", rsp_rdata, 8'h3C);

    // Back-to-back: write 0x55 to 0x203 then read 0x202, req_valid held.
    rd_val = 8'h9A;
    issue(1'b1, 10'h203, 1'b0, 8'h55);
    check("b2b_wr_addr", addr_o, 10'h203);
    check("b2b_wr_rw", r_w_o, 0);
    req_we   = 1'b0;
    req_addr = 10'h202;
    for (int k = 1; k < 8; k++) step();
    check("b2b_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    t1 = cyc;
    check("b2b_rd_addr", addr_o, 10'h202);
    check("b2b_rd_rw", r_w_o, 1);
    check("b2b_wr_rsp", rsp_valid, 1);
    check("b2b_wr_rsp_we", rsp_we, 1);
    check("b2b_hold_oe", db_oe, 1);
    check("b2b_hold_db", db_o, 8'h55);
    check("b2b_rdata_keep", rsp_rdata, 8'h3C);
    step();
    check("b2b_rd_oe", db_oe, 0);
    n = 0;
    while (!rsp_valid && n < 16) begin
      step();
      n++;
    end
    check("b2b_gap", cyc - t1, 8);
    check("b2b_rd_rsp_we", rsp_we, 0);
    check("b2b_rd_data", rsp_rdata, 8'h9A);

    // Idle cycles keep the last address and stay in read.
    for (int k = 0; k < 16; k++) begin
      step();
      check("idle_rw", r_w_o, 1);
      check("idle_addr", addr_o, 10'h202);
      check("idle_oe", db_oe, 0);
      check("idle_rsp", rsp_valid, 0);
    end

    // Asynchronous IRQ fall reaches irq_n_sync on the second edge.
    #3;
    irq_n_i = 1'b0;
    #1;
    check("irq_async", irq_n_sync, 1);
    step();
    check("irq_stage1", irq_n_sync, 1);
    step();
    check("irq_sync", irq_n_sync, 0);
    irq_n_i = 1'b1;
    step();
    step();
    check("irq_release", irq_n_sync, 1);

    // rst pulsed at c=5 of a write abandons it and restarts RES hold.
    issue(1'b1, 10'h155, 1'b1, 8'h77);
    req_valid = 1'b0;
    for (int k = 1; k < 6; k++) step();
    check("mid_oe", db_oe, 1);
    rst = 1'b1;
    #1;
    check("mid_res_n", res_n_o, 0);
    check("mid_addr", addr_o, 0);
    check("mid_rw", r_w_o, 1);
    check("mid_rs0", rs0_o, 0);
    check("mid_oe_off", db_oe, 0);
    check("mid_db", db_o, 0);
    check("mid_phi2", phi2_o, 0);
    check("mid_rdata", rsp_rdata, 0);
    check("mid_rsp", rsp_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    check_res_hold();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
